scope_capture_buffer: RTL
=========================

Name: scope_capture_buffer

Overview:
- Acquisition stage directly upstream of the oscilloscope display renderer.
- Accepts an 8-bit ADC sample stream with a valid strobe and detects a level/slope trigger.
- Captures DEPTH consecutive samples into an internal dual-port RAM, then freezes the frame.
- The renderer reads the frozen frame by column address while the next acquisition stays idle until re-armed.

Parameters:
- DATA_W, 8, sample width in bits.
- DEPTH, 1024, samples per frame; must be a power of 2.
- ADDR_W, $clog2(DEPTH), read/write address width.
- AUTO_TIMEOUT, 65535, valid samples seen in ARMED without a trigger before a forced trigger; used only when SCOPE_AUTO_TRIG_EN is defined.

Ports:
- clk  in  1  system clock; this block has one clock; reset is asynchronous and active-low.
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  qualifies sample for one cycle.
- sample  in  DATA_W  ADC sample, unsigned.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_slope  in  1  0 = rising edge, 1 = falling edge.
- arm  in  1  single-cycle request to start an acquisition.
- rd_addr  in  ADDR_W  renderer read address (column index).
- rd_data  out  DATA_W  registered RAM read data.
- frame_ready  out  1  high while a complete frame is held (state DONE).
- busy  out  1  high in ARMED or CAPTURE.
- triggered_auto  out  1  last frame was force-triggered; tied 0 when the macro is absent.

Behaviour:
- Reset (reset = 0, async):
  - State goes to IDLE.
  - rd_data, frame_ready, busy, triggered_auto = 0.
  - Write pointer = 0, prev_valid = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, ARMED, CAPTURE, DONE. Registered; busy and frame_ready are registered decodes of the state.
- IDLE: arm = 1 → ARMED next cycle; prev_valid cleared.
- ARMED:
  - On each sample_valid, sample is latched into prev and prev_valid is set.
  - Rising trigger: prev_valid && prev < trig_level && sample >= trig_level.
  - Falling trigger: prev_valid && prev > trig_level && sample <= trig_level.
  - The first valid sample after arming can never trigger.
  - On trigger: the triggering sample is written to address 0, write pointer = 1, state → CAPTURE.
- CAPTURE:
  - Each sample_valid writes sample to the write pointer, then increments it.
  - When the write at address DEPTH-1 occurs, state → DONE on the same edge and the pointer wraps to 0.
  - Gaps in sample_valid only stall the capture; they are not errors.
- DONE:
  - frame_ready = 1 until arm.
  - arm → ARMED next cycle; frame_ready falls on that edge.
- arm while in ARMED or CAPTURE is ignored.
- trig_level and trig_slope are sampled live each cycle; changing them in ARMED takes effect immediately.
- Read port:
  - rd_data = RAM[rd_addr] with exactly 1-cycle latency, in every state.
  - Reads at an address being written in the same cycle return the old data (read-first).
  - Frame content is stable only while frame_ready = 1.
- Reset mid-CAPTURE aborts the capture. The partial frame stays in RAM, but frame_ready remains 0 until a full capture completes.

Optional Feature:
- Macro: SCOPE_AUTO_TRIG_EN.
- When defined:
  - A timeout counter runs in ARMED, counting valid samples; it is cleared on entry to ARMED.
  - When the count reaches AUTO_TIMEOUT without a trigger, the next valid sample is treated as a trigger.
  - triggered_auto is set on that edge and held until the next arm.
  - A genuine trigger clears triggered_auto.
- When absent: no counter is built, the block waits indefinitely in ARMED, and triggered_auto is constant 0.

Decomposition:
- Shared package scope_pkg holds:
  - DATA_W default;
  - state enum capture_state_t {IDLE, ARMED, CAPTURE, DONE};
  - slope constants SLOPE_RISE = 1'b0, SLOPE_FALL = 1'b1.
- One natural sub-module, scope_dpram: simple dual-port RAM with synchronous write on port A and registered read-first read on port B, inferable as block RAM.

Test Plan (DEPTH = 16, AUTO_TIMEOUT = 8 for bench):
- Rising trigger: arm, level 0x80, ramp 0x70,0x78,0x80,0x88,... → frame captured with RAM[0] = 0x80, RAM[1] = 0x88; frame_ready rises after the 16th captured sample; busy falls at the same edge.
- Falling trigger: slope = 1, level 0x40, sequence 0x50,0x40 → RAM[0] = 0x40. Sequence 0x40,0x30 (no crossing from above) → remains ARMED.
- Valid gaps and read latency:
  - Toggle sample_valid 1-of-3 during CAPTURE → exactly 16 samples stored, in order.
  - Read rd_addr = 5 → rd_data shows RAM[5] one cycle later.
- Arm handling:
  - arm pulsed in CAPTURE → ignored, frame completes normally.
  - arm in DONE → frame_ready = 0 next cycle, busy = 1.
- Reset mid-CAPTURE:
  - Assert reset after 7 writes → all outputs 0 immediately, state IDLE.
  - Re-arm with no trigger → frame_ready stays 0.
- With SCOPE_AUTO_TRIG_EN: constant 0x10 input, level 0x80 → forced trigger on the 9th valid sample, triggered_auto = 1, frame completes.

Source files
------------

// File: rtl/scope_pkg.sv
// scope_pkg: definitions shared by the scope capture slice.
//   DEFAULT_DATA_W   - default ADC sample width
//   capture_state_t  - acquisition FSM states
//   SLOPE_RISE/FALL  - encodings of the trig_slope input
package scope_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/scope_dpram.sv
// scope_dpram: simple dual-port RAM for one captured frame.
//   Port A (write): wr_en, wr_addr, wr_data - synchronous write.
//   Port B (read) : rd_addr -> rd_data, registered, 1-cycle latency,
//                   read-first on a same-address collision.
//   reset (async, active-low) clears only the read register, never the array.
module scope_dpram
  import scope_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---- read register: non-blocking update returns pre-write contents ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/scope_capture_buffer.sv
// scope_capture_buffer: oscilloscope acquisition stage.
// Watches an ADC sample stream for a level/slope trigger, captures DEPTH
// consecutive valid samples into a frame RAM, then holds the frame for the
// display renderer until re-armed.
//   clk, reset      - single clock, asynchronous active-low reset
//   sample_valid    - qualifies sample
//   sample          - unsigned ADC sample
//   trig_level      - unsigned trigger threshold (used live)
//   trig_slope      - 0 rising, 1 falling (used live)
//   arm             - start an acquisition from IDLE or DONE
//   rd_addr/rd_data - renderer read port, 1-cycle latency
//   frame_ready     - a complete frame is held
//   busy            - waiting for trigger or capturing
//   triggered_auto  - last frame was force-triggered
// Optional feature macro SCOPE_AUTO_TRIG_EN: forces a trigger after
// AUTO_TIMEOUT valid samples in ARMED without a real trigger. Without it
// the block waits indefinitely and triggered_auto is constant 0.
module scope_capture_buffer
  import scope_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  output logic              busy,
  output logic              triggered_auto
);

  if (((DEPTH & (DEPTH - 1)) != 0) || (AUTO_TIMEOUT < 1)) begin : g_bad_cfg
    $error("scope_capture_buffer: DEPTH must be a power of 2 and AUTO_TIMEOUT >= 1");
  end

  capture_state_t    state, state_nxt;
  logic [DATA_W-1:0] prev_sample;
  logic              prev_valid;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              arm_accept;
  logic              trig_genuine;
  logic              auto_hit;
  logic              trig_fire;

  assign arm_accept = arm && ((state == IDLE) || (state == DONE));

  // Threshold compare uses the live level/slope; prev_valid keeps the first
  // sample after arming from ever triggering.
  always_comb begin
    trig_genuine = 1'b0;
    if ((state == ARMED) && sample_valid && prev_valid) begin
      if (trig_slope == SLOPE_FALL) begin
        trig_genuine = (prev_sample > trig_level) && (sample <= trig_level);
      end else begin
        trig_genuine = (prev_sample < trig_level) && (sample >= trig_level);
      end
    end
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_count;
  logic            to_hit;
  logic            trig_auto_q;

  assign to_hit   = (to_count == TO_W'(AUTO_TIMEOUT));
  assign auto_hit = (state == ARMED) && sample_valid && to_hit && !trig_genuine;

  // Counter is zero in every state but ARMED, so it starts clean on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_count <= '0;
    end else if (state != ARMED) begin
      to_count <= '0;
    end else if (sample_valid && !to_hit) begin
      to_count <= to_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_auto_q <= 1'b0;
    end else if (arm_accept || trig_genuine) begin
      trig_auto_q <= 1'b0;
    end else if (auto_hit) begin
      trig_auto_q <= 1'b1;
    end
  end

  assign triggered_auto = trig_auto_q;
`else
  assign auto_hit       = 1'b0;
  assign triggered_auto = 1'b0;
`endif

  assign trig_fire = trig_genuine || auto_hit;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = '0;
    unique case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (trig_fire) begin
          wr_en     = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          wr_en   = 1'b1;
          wr_addr = wr_ptr;
          if (wr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (arm) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control registers: state, flags decoded from next state, pointer ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      wr_ptr      <= '0;
      prev_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
      frame_ready <= (state_nxt == DONE);
      if ((state == ARMED) && trig_fire) begin
        wr_ptr <= ADDR_W'(1);
      end else if ((state == CAPTURE) && sample_valid) begin
        // Natural wrap to 0 after DEPTH-1 since DEPTH is a power of 2.
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (state != ARMED) begin
        prev_valid <= 1'b0;
      end else if (sample_valid) begin
        prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ARMED) && sample_valid) begin
      prev_sample <= sample;
    end
  end

  scope_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (sample),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
